// File: rtl/kmkz_defs.sv
// Shared definitions for the register-file control slice: FSM encoding and clear-sequence bound.
// The CLEAR state exists only when URV_RF_CLEAR_EN is defined.
package kmkz_defs;

    localparam logic [4:0] CLR_LAST = 5'd31;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WRITE = 3'd1,
        ST_RADDR = 3'd2,
        ST_RDATA = 3'd3,
        ST_DONE  = 3'd4
`ifdef URV_RF_CLEAR_EN
        , ST_CLEAR = 3'd5
`endif
    } rf_state_e;

endpackage

// File: rtl/urv_rf_ctrl.sv
// Register-file port arbiter: merges the writeback and rs1 ports with debug register access,
// and optionally zeroes x1..x31 after reset when URV_RF_CLEAR_EN is defined.
module urv_rf_ctrl
    import kmkz_defs::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [4:0]  w_rd_i,
    input  logic [31:0] w_rd_value_i,
    input  logic        w_rd_store_i,
    input  logic [4:0]  rf_rs1_i,
    input  logic        d_stall_i,
    input  logic        core_halt_i,
    input  logic        dbg_req_i,
    input  logic        dbg_we_i,
    input  logic [4:0]  dbg_addr_i,
    input  logic [31:0] dbg_wdata_i,
    output logic        dbg_ack_o,
    output logic [31:0] dbg_rdata_o,
    output logic [4:0]  rf_rd_o,
    output logic [31:0] rf_rd_value_o,
    output logic        rf_rd_store_o,
    output logic [4:0]  rf_rs1_o,
    output logic        rf_stall_o,
    input  logic [31:0] rf_rs1_value_i,
    output logic        core_stall_o
);

`ifdef URV_RF_CLEAR_EN
    localparam rf_state_e RESET_STATE = ST_CLEAR;
`else
    localparam rf_state_e RESET_STATE = ST_IDLE;
`endif

    rf_state_e   r_state;
    rf_state_e   w_next;
    logic [4:0]  r_rd_addr;
    logic [31:0] r_rdata;
`ifdef URV_RF_CLEAR_EN
    logic [4:0]  r_clr_cnt;
    logic        w_clr_adv;
`endif

    // The read address is latched in RADDR so the x0 check matches the address actually read.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state   <= RESET_STATE;
            r_rd_addr <= 5'd0;
            r_rdata   <= 32'd0;
`ifdef URV_RF_CLEAR_EN
            r_clr_cnt <= 5'd1;
`endif
        end else begin
            r_state <= w_next;
            if (r_state == ST_RADDR) begin
                r_rd_addr <= dbg_addr_i;
            end
            if (r_state == ST_RDATA && dbg_req_i) begin
                r_rdata <= (r_rd_addr == 5'd0) ? 32'd0 : rf_rs1_value_i;
            end
`ifdef URV_RF_CLEAR_EN
            if (w_clr_adv && r_clr_cnt != CLR_LAST) begin
                r_clr_cnt <= r_clr_cnt + 5'd1;
            end
`endif
        end
    end

    // Ports default to the pipeline; a dropped request removes any override in the same cycle.
    always_comb begin
        w_next        = r_state;
        rf_rd_o       = w_rd_i;
        rf_rd_value_o = w_rd_value_i;
        rf_rd_store_o = w_rd_store_i;
        rf_rs1_o      = rf_rs1_i;
        rf_stall_o    = d_stall_i;
`ifdef URV_RF_CLEAR_EN
        w_clr_adv     = 1'b0;
`endif
        case (r_state)
`ifdef URV_RF_CLEAR_EN
            ST_CLEAR: begin
                if (!w_rd_store_i) begin
                    rf_rd_o       = r_clr_cnt;
                    rf_rd_value_o = 32'd0;
                    rf_rd_store_o = 1'b1;
                    w_clr_adv     = 1'b1;
                    if (r_clr_cnt == CLR_LAST) begin
                        w_next = ST_IDLE;
                    end
                end
            end
`endif
            ST_IDLE: begin
                if (dbg_req_i && core_halt_i) begin
                    w_next = dbg_we_i ? ST_WRITE : ST_RADDR;
                end
            end
            ST_WRITE: begin
                if (!dbg_req_i) begin
                    w_next = ST_IDLE;
                end else if (!w_rd_store_i) begin
                    rf_rd_o       = dbg_addr_i;
                    rf_rd_value_o = dbg_wdata_i;
                    rf_rd_store_o = 1'b1;
                    w_next        = ST_DONE;
                end
            end
            ST_RADDR: begin
                if (!dbg_req_i) begin
                    w_next = ST_IDLE;
                end else begin
                    rf_rs1_o   = dbg_addr_i;
                    rf_stall_o = 1'b0;
                    w_next     = ST_RDATA;
                end
            end
            ST_RDATA: begin
                if (!dbg_req_i) begin
                    w_next = ST_IDLE;
                end else begin
                    rf_rs1_o   = r_rd_addr;
                    rf_stall_o = 1'b1;
                    w_next     = ST_DONE;
                end
            end
            ST_DONE: begin
                rf_stall_o = 1'b1;
                w_next     = ST_IDLE;
            end
            default: begin
                w_next = RESET_STATE;
            end
        endcase
    end

    assign dbg_ack_o   = (r_state == ST_DONE);
    assign dbg_rdata_o = r_rdata;

`ifdef URV_RF_CLEAR_EN
    assign core_stall_o = (r_state == ST_CLEAR);
`else
    assign core_stall_o = 1'b0;
`endif

endmodule
